// File: rtl/vga_pkg.sv
// Shared constants for the VGA pattern generator: default 640x480 timing,
// the 3-bit pattern encoding and a full-scale colour helper.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam logic [2:0] PAT_BLACK = 3'd0;
  localparam logic [2:0] PAT_RED   = 3'd1;
  localparam logic [2:0] PAT_GREEN = 3'd2;
  localparam logic [2:0] PAT_BLUE  = 3'd3;
  localparam logic [2:0] PAT_WHITE = 3'd4;
  localparam logic [2:0] PAT_BARS  = 3'd5;
  localparam logic [2:0] PAT_CHECK = 3'd6;
  localparam logic [2:0] PAT_RAMP  = 3'd7;

  // All-ones value for a channel of width w (callers truncate to their width).
  function automatic logic [31:0] full_scale(input int unsigned w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pb_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted rising edge of the debounced level.
module pb_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  output logic rise
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    sync_q;
  logic          level;
  logic [CW-1:0] cnt;

  // Bring the raw button into the pixel clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], pb};
  end

  // Accept a new level only after DEB_CYCLES consecutive differing samples;
  // any sample equal to the current level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync_q[1];
        cnt   <= '0;
        rise  <= sync_q[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and test-pattern generator. Counters walk the
// raster; a single output register stage turns the counter position into
// syncs, data-enable and colour. Pattern changes land only on frame starts.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int COLOR_W    = 4,
  parameter bit SYNC_POL   = 1'b0,
  parameter int DEB_CYCLES = 4,
  parameter int CHK_LOG2   = 5
) (
  input  logic               vga_clk,
  input  logic               rst_n,
  input  logic               pb_enter,
  input  logic               pb_up,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               h_sync,
  output logic               v_sync,
  output logic               de,
  output logic               frame_start,
  output logic [2:0]         color_pattern
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BP_W    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [COLOR_W-1:0] FULL = COLOR_W'(full_scale(COLOR_W));

  logic [H_W-1:0]     h_cnt;
  logic [V_W-1:0]     v_cnt;
  logic [BP_W-1:0]    bar_pos;
  logic [2:0]         bar_idx;
  logic               h_last, v_last, frame_end;
  logic               active, hs_on, vs_on, chk_on;
  logic               up_rise, enter_rise;
  logic [2:0]         pending, commit_val, pat_cur;
  logic               commit_req, wrap_flag;
  logic [COLOR_W-1:0] r_n, g_n, b_n, ramp;

  pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(vga_clk), .rst_n(rst_n), .pb(pb_up), .rise(up_rise)
  );

  pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enter (
    .clk(vga_clk), .rst_n(rst_n), .pb(pb_enter), .rise(enter_rise)
  );

  assign h_last    = (h_cnt == H_W'(H_TOTAL - 1));
  assign v_last    = (v_cnt == V_W'(V_TOTAL - 1));
  assign frame_end = h_last && v_last;
  assign active    = (h_cnt < H_W'(H_ACTIVE)) && (v_cnt < V_W'(V_ACTIVE));
  assign hs_on     = (h_cnt >= H_W'(H_ACTIVE + H_FP)) &&
                     (h_cnt <  H_W'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_on     = (v_cnt >= V_W'(V_ACTIVE + V_FP)) &&
                     (v_cnt <  V_W'(V_ACTIVE + V_FP + V_SYNC));
  assign chk_on    = 1'(h_cnt >> CHK_LOG2) ^ 1'(v_cnt >> CHK_LOG2);
  assign ramp      = COLOR_W'(h_cnt >> 4);

  // Raster counters plus a bar tracker that follows h_cnt without a divider.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      bar_pos <= '0;
      bar_idx <= '0;
    end else begin
      if (h_last) begin
        h_cnt   <= '0;
        v_cnt   <= v_last ? '0 : v_cnt + 1'b1;
        bar_pos <= '0;
        bar_idx <= '0;
      end else begin
        h_cnt <= h_cnt + 1'b1;
        if (bar_pos == BP_W'(BAR_W - 1)) begin
          bar_pos <= '0;
          bar_idx <= bar_idx + 1'b1;
        end else begin
          bar_pos <= bar_pos + 1'b1;
        end
      end
    end
  end

  // Pattern selection: pending advances on up, enter snapshots it, and the
  // snapshot is applied only at the last pixel of the frame. The enter
  // update sits after the boundary update so an enter on that exact cycle
  // stays queued for the next frame.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      commit_val <= '0;
      commit_req <= 1'b0;
      pat_cur    <= PAT_BLACK;
    end else begin
      if (up_rise) pending <= pending + 1'b1;
      if (frame_end && commit_req) begin
        pat_cur    <= commit_val;
        commit_req <= 1'b0;
      end
      if (enter_rise) begin
        commit_req <= 1'b1;
        commit_val <= pending;
      end
    end
  end

  // Colour for the current counter position; blanking forces black.
  always_comb begin
    r_n = '0;
    g_n = '0;
    b_n = '0;
    if (active) begin
      case (pat_cur)
        PAT_RED:   r_n = FULL;
        PAT_GREEN: g_n = FULL;
        PAT_BLUE:  b_n = FULL;
        PAT_WHITE: begin r_n = FULL; g_n = FULL; b_n = FULL; end
        PAT_BARS: begin
          r_n = bar_idx[2] ? FULL : '0;
          g_n = bar_idx[1] ? FULL : '0;
          b_n = bar_idx[0] ? FULL : '0;
        end
        PAT_CHECK: if (chk_on) begin r_n = FULL; g_n = FULL; b_n = FULL; end
        PAT_RAMP:  begin r_n = ramp; g_n = ramp; b_n = ramp; end
        default:   ;
      endcase
    end
  end

  // Output stage: every output is registered from the same counter value.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      red           <= '0;
      green         <= '0;
      blue          <= '0;
      h_sync        <= ~SYNC_POL;
      v_sync        <= ~SYNC_POL;
      de            <= 1'b0;
      frame_start   <= 1'b0;
      color_pattern <= PAT_BLACK;
      wrap_flag     <= 1'b0;
    end else begin
      red           <= r_n;
      green         <= g_n;
      blue          <= b_n;
      h_sync        <= hs_on ? SYNC_POL : ~SYNC_POL;
      v_sync        <= vs_on ? SYNC_POL : ~SYNC_POL;
      de            <= active;
      frame_start   <= wrap_flag;
      color_pattern <= pat_cur;
      wrap_flag     <= frame_end;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen with a small raster (24x12). A behavioural model
// tracks the output pixel position and displayed pattern arithmetically.
module tb_vga_pattern_gen;

  localparam int HA = 16, HF = 2, HS = 4, HB = 2, HT = 24;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 1, VT = 12;

  logic       vga_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pb_enter = 1'b0;
  logic       pb_up = 1'b0;
  logic [3:0] red, green, blue;
  logic       h_sync, v_sync, de, frame_start;
  logic [2:0] color_pattern;

  int n_tests = 0;
  int n_fail  = 0;

  // model: (mh,mv) is the pixel the next clock will present
  int   mh = 0, mv = 0, cur_h = 0, cur_v = 0;
  bit   fresh = 1'b1;
  int   m_pat = 0, m_pend = 0, m_val = 0;
  bit   m_req = 1'b0;
  logic [18:0] exp_bus;
  wire  [18:0] act_bus = {red, green, blue, h_sync, v_sync, de, frame_start, color_pattern};

  always #5 vga_clk = ~vga_clk;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .COLOR_W(4), .SYNC_POL(1'b0), .DEB_CYCLES(4), .CHK_LOG2(1)
  ) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .pb_enter(pb_enter), .pb_up(pb_up),
    .red(red), .green(green), .blue(blue), .h_sync(h_sync), .v_sync(v_sync),
    .de(de), .frame_start(frame_start), .color_pattern(color_pattern)
  );

  function automatic logic [11:0] pix(input int p, input int h, input int v);
    int r, g, b, i;
    r = 0; g = 0; b = 0;
    if (h < HA && v < VA) begin
      case (p)
        1: r = 15;
        2: g = 15;
        3: b = 15;
        4: begin r = 15; g = 15; b = 15; end
        5: begin
          i = h / (HA / 8);
          r = (i >= 4) ? 15 : 0;
          g = ((i / 2) % 2 == 1) ? 15 : 0;
          b = (i % 2 == 1) ? 15 : 0;
        end
        6: if (((h / 2) % 2) != ((v / 2) % 2)) begin r = 15; g = 15; b = 15; end
        7: begin r = (h / 16) % 16; g = r; b = r; end
        default: ;
      endcase
    end
    return {4'(r), 4'(g), 4'(b)};
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; fresh = 1'b1;
    m_pat = 0; m_pend = 0; m_val = 0; m_req = 1'b0;
  endtask

  // advance one clock and compute what the outputs must now show
  task automatic tick();
    logic fs, hs, vs, dd;
    @(posedge vga_clk);
    #1;
    fs = (mh == 0 && mv == 0 && !fresh);
    fresh = 1'b0;
    if (fs && m_req) begin m_pat = m_val; m_req = 1'b0; end
    hs = !(mh >= HA + HF && mh < HA + HF + HS);
    vs = !(mv >= VA + VF && mv < VA + VF + VS);
    dd = (mh < HA && mv < VA);
    exp_bus = {pix(m_pat, mh, mv), hs, vs, dd, fs, 3'(m_pat)};
    cur_h = mh; cur_v = mv;
    mh = mh + 1;
    if (mh == HT) begin mh = 0; mv = (mv + 1) % VT; end
  endtask

  task automatic press_up();
    pb_up = 1'b1; repeat (10) tick();
    pb_up = 1'b0; repeat (10) tick();
    m_pend = (m_pend + 1) % 8;
  endtask

  // enter is pressed well away from the frame boundary
  task automatic press_enter();
    while (!(mv >= 1 && mv <= 7)) tick();
    pb_enter = 1'b1; repeat (10) tick();
    pb_enter = 1'b0; repeat (10) tick();
    m_req = 1'b1; m_val = m_pend;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pb_up = 1'b0; pb_enter = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    n_tests++; if ({red, green, blue} !== 12'h000) begin n_fail++; $display("FAIL reset_rgb got %h want 000", {red, green, blue}); end
    n_tests++; if (h_sync !== 1'b1) begin n_fail++; $display("FAIL reset_hsync got %b want 1", h_sync); end
    n_tests++; if (v_sync !== 1'b1) begin n_fail++; $display("FAIL reset_vsync got %b want 1", v_sync); end
    n_tests++; if (de !== 1'b0) begin n_fail++; $display("FAIL reset_de got %b want 0", de); end
    n_tests++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs got %b want 0", frame_start); end
    n_tests++; if (color_pattern !== 3'd0) begin n_fail++; $display("FAIL reset_pat got %0d want 0", color_pattern); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_free_run();
    int hs_low, vs_low, de_hi, fs_n, first_hs;
    hs_low = 0; vs_low = 0; de_hi = 0; fs_n = 0; first_hs = -1;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      tick();
      n_tests++;
      if (act_bus !== exp_bus) begin n_fail++; $display("FAIL free_run (%0d,%0d) got %h want %h", cur_h, cur_v, act_bus, exp_bus); end
      if (h_sync === 1'b0) begin hs_low++; if (first_hs < 0) first_hs = i; end
      if (v_sync === 1'b0) vs_low++;
      if (de === 1'b1) de_hi++;
      if (frame_start === 1'b1) fs_n++;
    end
    n_tests++; if (hs_low != 96) begin n_fail++; $display("FAIL hsync_low_count got %0d want 96", hs_low); end
    n_tests++; if (first_hs != 18) begin n_fail++; $display("FAIL hsync_first got %0d want 18", first_hs); end
    n_tests++; if (vs_low != 96) begin n_fail++; $display("FAIL vsync_low_count got %0d want 96", vs_low); end
    n_tests++; if (de_hi != 256) begin n_fail++; $display("FAIL de_count got %0d want 256", de_hi); end
    n_tests++; if (fs_n != 1) begin n_fail++; $display("FAIL frame_start_count got %0d want 1", fs_n); end
  endtask

  task automatic test_commit();
    repeat (3) press_up();
    press_enter();
    for (int i = 0; i < 400; i++) begin
      tick();
      n_tests++;
      if (act_bus !== exp_bus) begin n_fail++; $display("FAIL commit_wait (%0d,%0d) got %h want %h", cur_h, cur_v, act_bus, exp_bus); end
      if (exp_bus[3]) break;
    end
    n_tests++; if (color_pattern !== 3'd3) begin n_fail++; $display("FAIL commit_pat got %0d want 3", color_pattern); end
    for (int i = 0; i < HT * VT; i++) begin
      tick();
      if (cur_h < HA && cur_v < VA) begin
        n_tests++;
        if ({red, green, blue} !== 12'h00F) begin n_fail++; $display("FAIL commit_blue (%0d,%0d) got %h want 00f", cur_h, cur_v, {red, green, blue}); end
      end
    end
  endtask

  task automatic test_debounce();
    int seq [6] = '{0, 1, 0, 1, 1, 0};
    pb_up = 1'b1; tick(); pb_up = 1'b0; tick(); pb_up = 1'b1; tick();
    repeat (10) tick();
    foreach (seq[k]) begin pb_up = seq[k][0]; tick(); end
    pb_up = 1'b0; repeat (10) tick();
    m_pend = (m_pend + 1) % 8;
    press_enter();
    for (int i = 0; i < 400; i++) begin
      tick();
      n_tests++;
      if (act_bus !== exp_bus) begin n_fail++; $display("FAIL debounce_wait (%0d,%0d) got %h want %h", cur_h, cur_v, act_bus, exp_bus); end
      if (exp_bus[3]) break;
    end
    n_tests++; if (color_pattern !== 3'd4) begin n_fail++; $display("FAIL debounce_pat got %0d want 4", color_pattern); end
  endtask

  task automatic test_bars();
    press_up();
    press_enter();
    for (int i = 0; i < 400; i++) begin
      tick();
      n_tests++;
      if (act_bus !== exp_bus) begin n_fail++; $display("FAIL bars_wait (%0d,%0d) got %h want %h", cur_h, cur_v, act_bus, exp_bus); end
      if (exp_bus[3]) break;
    end
    for (int i = 0; i < HT * VT; i++) begin
      tick();
      n_tests++;
      if (act_bus !== exp_bus) begin n_fail++; $display("FAIL bars_frame (%0d,%0d) got %h want %h", cur_h, cur_v, act_bus, exp_bus); end
      if (cur_v == 0 && cur_h == 4) begin
        n_tests++; if ({red, green, blue} !== 12'h0F0) begin n_fail++; $display("FAIL bar_h4 got %h want 0f0", {red, green, blue}); end
      end
      if (cur_v == 0 && cur_h == 14) begin
        n_tests++; if ({red, green, blue} !== 12'hFFF) begin n_fail++; $display("FAIL bar_h14 got %h want fff", {red, green, blue}); end
      end
      if (cur_v == 0 && cur_h == 20) begin
        n_tests++; if ({red, green, blue} !== 12'h000) begin n_fail++; $display("FAIL bar_blank got %h want 000", {red, green, blue}); end
      end
    end
  endtask

  task automatic test_same_cycle();
    while (!(mv >= 1 && mv <= 7)) tick();
    pb_up = 1'b1; pb_enter = 1'b1; repeat (10) tick();
    pb_up = 1'b0; pb_enter = 1'b0; repeat (10) tick();
    m_req = 1'b1; m_val = m_pend; m_pend = (m_pend + 1) % 8;
    for (int i = 0; i < 400; i++) begin
      tick();
      n_tests++;
      if (act_bus !== exp_bus) begin n_fail++; $display("FAIL same_wait (%0d,%0d) got %h want %h", cur_h, cur_v, act_bus, exp_bus); end
      if (exp_bus[3]) break;
    end
    n_tests++; if (color_pattern !== 3'd5) begin n_fail++; $display("FAIL same_commit got %0d want 5", color_pattern); end
    press_enter();
    for (int i = 0; i < 400; i++) begin
      tick();
      n_tests++;
      if (act_bus !== exp_bus) begin n_fail++; $display("FAIL same_next_wait (%0d,%0d) got %h want %h", cur_h, cur_v, act_bus, exp_bus); end
      if (exp_bus[3]) break;
    end
    n_tests++; if (color_pattern !== 3'd6) begin n_fail++; $display("FAIL same_pending got %0d want 6", color_pattern); end
  endtask

  task automatic test_random_patterns();
    int target, ups;
    for (int r = 0; r < 3; r++) begin
      target = (r == 0) ? 6 : int'($urandom_range(0, 7));
      ups = (target - m_pend + 8) % 8;
      repeat (ups) press_up();
      press_enter();
      for (int i = 0; i < 400; i++) begin
        tick();
        n_tests++;
        if (act_bus !== exp_bus) begin n_fail++; $display("FAIL rand_wait (%0d,%0d) got %h want %h", cur_h, cur_v, act_bus, exp_bus); end
        if (exp_bus[3]) break;
      end
      for (int i = 0; i < HT * VT; i++) begin
        tick();
        n_tests++;
        if (act_bus !== exp_bus) begin n_fail++; $display("FAIL rand_frame p=%0d (%0d,%0d) got %h want %h", target, cur_h, cur_v, act_bus, exp_bus); end
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat ((4 - m_pend + 8) % 8) press_up();
    press_enter();
    for (int i = 0; i < 400; i++) begin
      tick();
      if (exp_bus[3]) break;
    end
    while (!(cur_v == 1 && cur_h == 5)) tick();
    n_tests++; if (red !== 4'hF) begin n_fail++; $display("FAIL rmid_pre_red got %h want f", red); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({red, green, blue} !== 12'h000) begin n_fail++; $display("FAIL rmid_rgb got %h want 000", {red, green, blue}); end
    n_tests++; if ({h_sync, v_sync} !== 2'b11) begin n_fail++; $display("FAIL rmid_sync got %b want 11", {h_sync, v_sync}); end
    n_tests++; if (color_pattern !== 3'd0) begin n_fail++; $display("FAIL rmid_pat got %0d want 0", color_pattern); end
    n_tests++; if ({de, frame_start} !== 2'b00) begin n_fail++; $display("FAIL rmid_de_fs got %b want 00", {de, frame_start}); end
    repeat (2) @(posedge vga_clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < HT * VT + 10; i++) begin
      tick();
      n_tests++;
      if (act_bus !== exp_bus) begin n_fail++; $display("FAIL rmid_restart (%0d,%0d) got %h want %h", cur_h, cur_v, act_bus, exp_bus); end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_commit();
    test_debounce();
    test_bars();
    test_same_cycle();
    test_random_patterns();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised VGA timing and test-pattern generator, the successor to the fixed 640x480, 1-bit-per-colour `vga_con` controller. It produces h_sync, v_sync and a data-enable from configurable timing parameters, and drives COLOR_W-bit RGB from one of eight selectable patterns. The pattern is chosen with debounced pushbuttons, and a new selection is committed only at a frame boundary so the picture never tears. It sits between the board pushbuttons and the VGA DAC pins.

## Interface
- H_ACTIVE, 640, visible pixels per line (must be divisible by 8)
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch in lines
- COLOR_W, 4, bits per colour channel
- SYNC_POL, 0, sync asserted level (0 = active-low)
- DEB_CYCLES, 4, consecutive stable samples before a button level is accepted
- CHK_LOG2, 5, log2 of the checkerboard square size
- vga_clk  in  1  pixel clock, single clock domain
- rst_n  in  1  asynchronous reset, active-low
- pb_enter  in  1  raw button, commits the pending pattern
- pb_up  in  1  raw button, advances the pending pattern
- red / green / blue  out  COLOR_W each  pixel colour, registered
- h_sync / v_sync  out  1  sync outputs, registered, polarity set by SYNC_POL
- de  out  1  high while the current pixel is in the active region
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)
- color_pattern  out  3  pattern currently displayed

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps and counts 0..V_TOTAL-1.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- h_sync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). v_sync is asserted likewise on v_cnt.
- Button path: 2-flop synchroniser, then debounce. The debounced level changes only after DEB_CYCLES consecutive equal samples. Only debounced rising edges act.
- pb_up edge: pending <= pending+1, wrapping mod 8.
- pb_enter edge: commit_req <= 1 and commit_val <= pending, taking the pre-increment value if pb_up fires in the same cycle. A later enter before the frame boundary overwrites commit_val.
- Frame boundary is (h_cnt,v_cnt) = (H_TOTAL-1, V_TOTAL-1). At that point, if commit_req is set, color_pattern <= commit_val and commit_req <= 0.
- Full scale is all ones. Outside the active region, RGB = 0 regardless of pattern.
- Patterns:
  - 0: black
  - 1: red
  - 2: green
  - 3: blue
  - 4: white
  - 5: 8 vertical bars. Bar index i = h_cnt/(H_ACTIVE/8) (implement with a bar counter, no divider). Each channel is full scale or 0 from {i[2], i[1], i[0]} for {r, g, b}.
  - 6: checkerboard, white where h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2], else black.
  - 7: grey ramp, each channel = (h_cnt >> 4) truncated to COLOR_W bits.

## Timing
- Reset values:
  - outputs: RGB = 0, de = 0, frame_start = 0, color_pattern = 0, h_sync = v_sync = ~SYNC_POL.
  - internal state: h_cnt = v_cnt = 0, pending = 0, commit_req = 0, debounced levels = 0.
- Latency: every output reflects the counter value of the previous cycle (1-cycle registered pipeline). All outputs stay mutually aligned.
- Button-to-pending latency: 2 (sync) + DEB_CYCLES cycles after the raw input settles.
- A commit becomes visible on the pixel that carries frame_start, never mid-frame.
- Reset asserted mid-frame forces all reset values immediately, without waiting for a clock. The first clock after release outputs pixel (0,0) with frame_start = 0; the first frame_start comes after one full frame.

## Structure
- Package vga_pkg holds the default timing constants, the 3-bit pattern encoding constants (PAT_BLACK..PAT_RAMP) and the full-scale helper.
- Sub-module pb_debounce (synchroniser, stability counter, rising-edge pulse output) is instantiated twice. Everything else lives in vga_pattern_gen.

## Test plan
Bench parameters: H 16/2/4/2 (H_TOTAL 24), V 8/1/2/1 (V_TOTAL 12), COLOR_W 4, DEB_CYCLES 4, CHK_LOG2 1.
- Reset release, free-run -> h_sync low 4 of every 24 cycles, starting at output pixel h = 18. v_sync low 48 of every 288 cycles. de high 16 cycles per line on 8 lines. frame_start every 288 cycles.
- pb_up toggling every cycle for 3 cycles, then held high 10 -> exactly one pending increment. Releasing with bounce -> no further change.
- 3 clean pb_up presses, then pb_enter mid-frame -> color_pattern stays 0 until frame_start, then reads 3. Active pixels have blue = 4'hF, red = green = 0.
- Pattern 5 -> output pixel h = 4 gives bar 2 (green = 4'hF only). h = 14 gives bar 7 (white). Blanking pixels are 0.
- pb_up and pb_enter debounced edges in the same cycle with pending = 5 -> committed value 5, pending becomes 6.
- rst_n pulsed low mid-line with pattern 4 active -> RGB 0, syncs high and color_pattern 0 asynchronously. Timing restarts at (0,0) after release.
